seq_detector_gen: RTL

Parametrised serial bit-pattern detector, the next generation of `seqDetector`. It supports a configurable pattern length and Moore/Mealy output timing, with overlapping or non-overlapping match semantics. It adds a valid qualifier, a pattern that can be reloaded at run time, and a saturating match counter. It sits directly on a serial bit stream and produces a single-cycle match pulse for downstream logic.

---
 rtl/seq_det_pkg.sv | 20 ++
 rtl/sat_counter.sv | 32 +++
 rtl/seq_detector_gen.sv | 80 ++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_det_pkg
// Brief    : Shared mode constants and sizing helper for seq_detector_gen.
// Revision : 1.0
// ============================================================================
package seq_det_pkg;

    localparam bit SD_MEALY      = 1'b0;
    localparam bit SD_MOORE      = 1'b1;
    localparam bit SD_NO_OVERLAP = 1'b0;
    localparam bit SD_OVERLAP    = 1'b1;

    // Width of a counter that must hold the values 0..l inclusive.
    function automatic int fill_w(input int l);
        return $clog2(l + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Saturating up-counter; clear takes priority over increment.
// Revision : 1.0
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != {W{1'b1}})) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/seq_detector_gen.sv
`default_nettype none
// ============================================================================
// Module   : seq_detector_gen
// Brief    : Parametrised serial pattern detector, Moore/Mealy, overlap option.
// Revision : 1.0
// ============================================================================
module seq_detector_gen
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 MOORE   = 1'b1,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din,
    input  logic               din_valid,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               pat_load,
    input  logic               cnt_clear,
    output logic               dout,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam int                FILL_W     = fill_w(PAT_LEN);
    localparam logic [FILL_W-1:0] c_fill_max = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0] c_fill_thr = FILL_W'(PAT_LEN - 1);

    // The oldest history bit is shifted out by the window, so only L-1 are kept.
    logic [PAT_LEN-2:0] r_hist;
    logic [FILL_W-1:0]  r_fill;
    logic [PAT_LEN-1:0] r_pat;
    logic               r_dout;

    logic [PAT_LEN-1:0] w_win;
    logic               w_hit;

    assign w_win = {r_hist, din};
    assign w_hit = din_valid & ~pat_load & (r_fill >= c_fill_thr) & (w_win == r_pat);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hist <= '0;
            r_fill <= '0;
            r_pat  <= PATTERN;
            r_dout <= 1'b0;
        end else if (pat_load) begin
            r_pat  <= pat_in;
            r_fill <= '0;
            r_dout <= 1'b0;
        end else begin
            r_dout <= w_hit;
            if (din_valid) begin
                r_hist <= w_win[PAT_LEN-2:0];
                if (w_hit && (OVERLAP == SD_NO_OVERLAP)) begin
                    r_fill <= '0;
                end else if (r_fill != c_fill_max) begin
                    r_fill <= r_fill + FILL_W'(1);
                end
            end
        end
    end

    // Gated by reset so the pulse reads low while reset is held in either mode.
    assign dout = reset & ((MOORE == SD_MOORE) ? r_dout : w_hit);

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (w_hit),
        .clr   (cnt_clear),
        .q     (match_cnt)
    );

endmodule
`default_nettype wire
